// File: rtl/vtdl_mt.sv
// Tapped delay line: DEP-entry shift register read by NTAP independently addressed taps.
// Latency: tap t shows a sample t ce-edges after capture (+1 clk when REGOUT); no backpressure, ce gates shifting.
module vtdl_mt #(
  parameter  int WID    = 8,
  parameter  int DEP    = 16,
  parameter  int NTAP   = 2,
  parameter  int REGOUT = 0,
  localparam int AW     = $clog2(DEP),
  localparam int FW     = $clog2(DEP+1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                clr,
  input  logic [WID-1:0]      d,
  input  logic [NTAP*AW-1:0]  a,
  input  logic [NTAP-1:0]     a_ld,
  output logic [NTAP*WID-1:0] q,
  output logic [NTAP-1:0]     qv,
  output logic [FW-1:0]       fill
);

  logic [WID-1:0]      m [DEP];
  logic [AW-1:0]       tap [NTAP];
  logic [NTAP*WID-1:0] v;
  logic [NTAP-1:0]     c;

  // Storage carries no reset so it maps onto plain shift-register cells; fill alone decides validity.
  always_ff @(posedge clk) begin
    if (rst_n && ce && !clr) begin
      m[0] <= d;
      for (int n = 1; n < DEP; n++) m[n] <= m[n-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                            fill <= '0;
    else if (clr)                          fill <= '0;
    else if (ce && (fill != FW'(DEP)))     fill <= fill + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) tap[i] <= '0;
    end else begin
      for (int i = 0; i < NTAP; i++) begin
        if (a_ld[i])
          tap[i] <= (32'(a[i*AW +: AW]) >= DEP) ? AW'(DEP-1) : a[i*AW +: AW];
      end
    end
  end

  always_comb begin
    v = '0;
    c = '0;
    for (int i = 0; i < NTAP; i++) begin
      c[i] = fill > FW'(tap[i]);
      if (c[i]) v[i*WID +: WID] = m[tap[i]];
    end
  end

  generate
    if (REGOUT != 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q  <= '0;
          qv <= '0;
        end else begin
          q  <= v;
          qv <= c;
        end
      end
    end else begin : g_comb
      assign q  = v;
      assign qv = c;
    end
  endgenerate

endmodule

// File: tb/tb_vtdl_mt.sv
// Bench for vtdl_mt: three instances (DEP16 comb, DEP16 registered, DEP12 comb) share stimulus
// and are scored against a queue-based history model.
module tb_vtdl_mt;

  logic        clk = 1'b0;
  logic        rst_n, ce, clr;
  logic [7:0]  d;
  logic [7:0]  a;
  logic [1:0]  a_ld;
  logic [15:0] q0, q1, q2;
  logic [1:0]  qv0, qv1, qv2;
  logic [4:0]  f0, f1;
  logic [3:0]  f2;

  always #5 clk = ~clk;

  vtdl_mt #(.WID(8), .DEP(16), .NTAP(2), .REGOUT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a), .a_ld(a_ld),
    .q(q0), .qv(qv0), .fill(f0));
  vtdl_mt #(.WID(8), .DEP(16), .NTAP(2), .REGOUT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a), .a_ld(a_ld),
    .q(q1), .qv(qv1), .fill(f1));
  vtdl_mt #(.WID(8), .DEP(12), .NTAP(2), .REGOUT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .d(d), .a(a), .a_ld(a_ld),
    .q(q2), .qv(qv2), .fill(f2));

  // Reference model: newest-first sample history plus per-depth fill and tap values.
  logic [7:0] hist[$];
  int         deps[2] = '{16, 12};
  int         mfill[2] = '{0, 0};
  int         mtap[2][2] = '{'{0, 0}, '{0, 0}};

  typedef struct {
    logic [15:0] q0;  logic [1:0] qv0; int f0;
    logic [15:0] q1;  logic [1:0] qv1; int f1;
    logic [15:0] q2;  logic [1:0] qv2; int f2;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int npass = 0;

  function automatic logic [15:0] mq(int k);
    logic [15:0] r = '0;
    for (int i = 0; i < 2; i++)
      if (mfill[k] > mtap[k][i]) r[i*8 +: 8] = hist[mtap[k][i]];
    return r;
  endfunction

  function automatic logic [1:0] mqv(int k);
    logic [1:0] r = '0;
    for (int i = 0; i < 2; i++) r[i] = mfill[k] > mtap[k][i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [7:0] dv,
                      input logic [7:0] av, input logic [1:0] ld);
    exp_t        x;
    logic [15:0] pq;
    logic [1:0]  pqv;
    rst_n = r; ce = e; clr = c; d = dv; a = av; a_ld = ld;
    pq  = mq(0);
    pqv = mqv(0);
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 2; k++) begin
        mfill[k] = 0;
        mtap[k][0] = 0;
        mtap[k][1] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 2; i++)
          if (ld[i]) mtap[k][i] = (int'(av[i*4 +: 4]) >= deps[k]) ? deps[k] - 1 : int'(av[i*4 +: 4]);
      if (c) begin
        mfill[0] = 0;
        mfill[1] = 0;
      end else if (e) begin
        hist.push_front(dv);
        if (hist.size() > 16) void'(hist.pop_back());
        for (int k = 0; k < 2; k++) if (mfill[k] < deps[k]) mfill[k]++;
      end
    end
    x.q0 = mq(0);           x.qv0 = mqv(0);         x.f0 = mfill[0];
    x.q1 = r ? pq : 16'h0;  x.qv1 = r ? pqv : 2'b0; x.f1 = mfill[0];
    x.q2 = mq(1);           x.qv2 = mqv(1);         x.f2 = mfill[1];
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per presented cycle, independent of the driver.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("q_comb16",  32'(q0),  32'(x.q0));
        chk("qv_comb16", 32'(qv0), 32'(x.qv0));
        chk("fill16",    32'(f0),  32'(x.f0));
        chk("q_reg16",   32'(q1),  32'(x.q1));
        chk("qv_reg16",  32'(qv1), 32'(x.qv1));
        chk("fill_reg16",32'(f1),  32'(x.f1));
        chk("q_comb12",  32'(q2),  32'(x.q2));
        chk("qv_comb12", 32'(qv2), 32'(x.qv2));
        chk("fill12",    32'(f2),  32'(x.f2));
      end
    end
  end

  initial begin
    logic [7:0] dn;
    rst_n = 1'b0; ce = 1'b0; clr = 1'b0; d = '0; a = '0; a_ld = '0;
    @(negedge clk);
    #1;
    step(0, 0, 0, 8'h00, 8'h00, 2'b00);
    step(0, 1, 1, 8'h77, 8'h5A, 2'b11);
    step(1, 0, 0, 8'h00, {4'd5, 4'd0}, 2'b11);
    for (int k = 1; k <= 20; k++) step(1, 1, 0, 8'(k), 8'h00, 2'b00);
    step(1, 1, 1, 8'hAA, 8'h00, 2'b00);
    step(1, 0, 0, 8'h00, 8'h00, 2'b00);
    step(1, 1, 0, 8'h30, 8'h00, 2'b00);
    step(1, 0, 0, 8'h00, {4'd15, 4'd0}, 2'b10);
    for (int k = 0; k < 17; k++) step(1, 1, 0, 8'(8'h40 + k), 8'h00, 2'b00);
    step(1, 1, 0, 8'h60, {4'd3, 4'd13}, 2'b11);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 8'(8'h70 + k), 8'h00, 2'b00);
    for (int k = 0; k < 3; k++) step(1, 0, 0, 8'hEE, 8'h00, 2'b00);
    step(1, 0, 1, 8'h00, 8'h00, 2'b00);
    for (int k = 0; k < 10; k++) step(1, 1, 0, 8'(8'h80 + k), 8'h00, 2'b00);
    step(0, 1, 0, 8'h99, {4'd2, 4'd7}, 2'b11);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h00, 8'h00, 2'b00);
    for (int k = 0; k < 400; k++) begin
      dn = 8'($urandom);
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0),
           dn,
           8'($urandom),
           ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    step(1, 0, 0, 8'h00, 8'h00, 2'b00);
    step(1, 0, 0, 8'h00, 8'h00, 2'b00);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
